// File: rtl/calc_nport.sv
// Multi-port calculator core: per-port request queues feed one round-robin arbitrated
// add/sub/shift stage. Define CALC_ROTATE_EN to build rotate support for cmds 9/10.
module calc_nport #(
   parameter int PORTS  = 4,
   parameter int DATA_W = 32,
   parameter int QDEPTH = 4,
   parameter int TAG_W  = 2
) (
   input  logic                      c_clk,
   input  logic                      reset,
   input  logic [4*PORTS-1:0]        req_cmd_in,
   input  logic [DATA_W*PORTS-1:0]   req_data_in,
   input  logic [TAG_W*PORTS-1:0]    req_tag_in,
   output logic [PORTS-1:0]          req_full,
   output logic [2*PORTS-1:0]        out_resp,
   output logic [DATA_W*PORTS-1:0]   out_data,
   output logic [TAG_W*PORTS-1:0]    out_tag
);

   localparam int PW = (PORTS > 1) ? $clog2(PORTS) : 1;
   localparam int QW = $clog2(QDEPTH);
   localparam int SW = $clog2(DATA_W);

   typedef struct packed {
      logic [3:0]        cmd;
      logic [DATA_W-1:0] op1;
      logic [DATA_W-1:0] op2;
      logic [TAG_W-1:0]  tag;
   } entry_t;

   entry_t            w_head [PORTS];
   logic [PORTS-1:0]  w_nempty;
   logic [PORTS-1:0]  w_deq;
   logic              w_gnt_vld;
   logic [PW-1:0]     w_gnt;
   logic [PW:0]       w_idx;

   logic              r_d_vld;
   logic [PW-1:0]     r_d_port;
   entry_t            r_d;
   logic [PW-1:0]     r_ptr;

   logic [DATA_W:0]   w_sum;
   logic [SW-1:0]     w_sh;
   logic [1:0]        w_resp;
   logic [DATA_W-1:0] w_res;

   for (genvar g = 0; g < PORTS; g++) begin : g_port
      logic              r_pend;
      logic [3:0]        r_cmd;
      logic [DATA_W-1:0] r_op1;
      logic [TAG_W-1:0]  r_tag;
      logic [QW-1:0]     r_wptr;
      logic [QW-1:0]     r_rptr;
      logic [QW:0]       r_cnt;
      logic              r_full;
      entry_t            r_mem [QDEPTH];
      logic [3:0]        w_cmd;
      logic [QW:0]       w_cnt_nxt;
      logic [1:0]        r_oresp;
      logic [DATA_W-1:0] r_odata;
      logic [TAG_W-1:0]  r_otag;

      assign w_cmd       = req_cmd_in[4*g +: 4];
      assign w_deq[g]    = w_gnt_vld && (w_gnt == PW'(g));
      assign w_nempty[g] = (r_cnt != '0);
      assign w_head[g]   = r_mem[r_rptr];
      assign req_full[g] = r_full;
      assign out_resp[2*g +: 2]           = r_oresp;
      assign out_data[DATA_W*g +: DATA_W] = r_odata;
      assign out_tag[TAG_W*g +: TAG_W]    = r_otag;

      always_comb begin
         w_cnt_nxt = r_cnt;
         if (r_pend)   w_cnt_nxt = w_cnt_nxt + (QW+1)'(1);
         if (w_deq[g]) w_cnt_nxt = w_cnt_nxt - (QW+1)'(1);
      end

      // r_pend marks the op2 cycle; its command bits are ignored by construction
      always_ff @(posedge c_clk or posedge reset) begin
         if (reset) begin
            r_pend <= 1'b0;
            r_cmd  <= '0;
            r_op1  <= '0;
            r_tag  <= '0;
            r_wptr <= '0;
            r_rptr <= '0;
            r_cnt  <= '0;
            r_full <= 1'b0;
         end else begin
            r_cnt  <= w_cnt_nxt;
            r_full <= (w_cnt_nxt == (QW+1)'(QDEPTH));
            if (w_deq[g]) r_rptr <= r_rptr + QW'(1);
            if (r_pend) begin
               r_pend <= 1'b0;
               r_wptr <= r_wptr + QW'(1);
            end else if (w_cmd != 4'd0 && !r_full) begin
               r_pend <= 1'b1;
               r_cmd  <= w_cmd;
               r_op1  <= req_data_in[DATA_W*g +: DATA_W];
               r_tag  <= req_tag_in[TAG_W*g +: TAG_W];
            end
         end
      end

      always_ff @(posedge c_clk) begin
         if (r_pend) r_mem[r_wptr] <= {r_cmd, r_op1, req_data_in[DATA_W*g +: DATA_W], r_tag};
      end

      always_ff @(posedge c_clk or posedge reset) begin
         if (reset) begin
            r_oresp <= '0;
            r_odata <= '0;
            r_otag  <= '0;
         end else if (r_d_vld && r_d_port == PW'(g)) begin
            r_oresp <= w_resp;
            r_odata <= w_res;
            r_otag  <= r_d.tag;
         end else begin
            r_oresp <= '0;
            r_odata <= '0;
            r_otag  <= '0;
         end
      end
   end

   // r_ptr is the first port searched, i.e. one past the last grant
   always_comb begin
      w_gnt_vld = 1'b0;
      w_gnt     = '0;
      w_idx     = '0;
      for (int i = 0; i < PORTS; i++) begin
         w_idx = {1'b0, r_ptr} + (PW+1)'(i);
         if (w_idx >= (PW+1)'(PORTS)) w_idx = w_idx - (PW+1)'(PORTS);
         if (!w_gnt_vld && w_nempty[w_idx[PW-1:0]]) begin
            w_gnt_vld = 1'b1;
            w_gnt     = w_idx[PW-1:0];
         end
      end
   end

   always_ff @(posedge c_clk or posedge reset) begin
      if (reset) begin
         r_d_vld  <= 1'b0;
         r_d_port <= '0;
         r_d      <= '0;
         r_ptr    <= '0;
      end else begin
         r_d_vld <= w_gnt_vld;
         if (w_gnt_vld) begin
            r_d_port <= w_gnt;
            r_d      <= w_head[w_gnt];
            r_ptr    <= (w_gnt == PW'(PORTS-1)) ? '0 : w_gnt + PW'(1);
         end
      end
   end

   assign w_sum = {1'b0, r_d.op1} + {1'b0, r_d.op2};
   assign w_sh  = r_d.op2[SW-1:0];

`ifdef CALC_ROTATE_EN
   logic [SW:0] w_nsh;
   assign w_nsh = (SW+1)'(DATA_W) - {1'b0, w_sh};
`endif

   always_comb begin
      w_resp = 2'd3;
      w_res  = '0;
      case (r_d.cmd)
         4'd1: begin
            if (w_sum[DATA_W]) w_resp = 2'd2;
            else begin
               w_resp = 2'd1;
               w_res  = w_sum[DATA_W-1:0];
            end
         end
         4'd2: begin
            if (r_d.op2 > r_d.op1) w_resp = 2'd2;
            else begin
               w_resp = 2'd1;
               w_res  = r_d.op1 - r_d.op2;
            end
         end
         4'd5: begin
            w_resp = 2'd1;
            w_res  = r_d.op1 << w_sh;
         end
         4'd6: begin
            w_resp = 2'd1;
            w_res  = r_d.op1 >> w_sh;
         end
`ifdef CALC_ROTATE_EN
         // a shift by DATA_W yields zero, so rotate by 0 returns op1 unchanged
         4'd9: begin
            w_resp = 2'd1;
            w_res  = (r_d.op1 << w_sh) | (r_d.op1 >> w_nsh);
         end
         4'd10: begin
            w_resp = 2'd1;
            w_res  = (r_d.op1 >> w_sh) | (r_d.op1 << w_nsh);
         end
`endif
         default: begin
            w_resp = 2'd3;
            w_res  = '0;
         end
      endcase
   end

endmodule

// File: tb/tb_calc_nport.sv
// Self-checking bench for calc_nport: directed steps plus randomized traffic, all
// compared each cycle against a queue-based reference model.
module tb_calc_nport;

   localparam int P  = 4;
   localparam int DW = 32;
   localparam int QD = 4;
   localparam int TW = 2;

   logic              c_clk = 1'b0;
   logic              reset;
   logic [4*P-1:0]    req_cmd_in;
   logic [DW*P-1:0]   req_data_in;
   logic [TW*P-1:0]   req_tag_in;
   logic [P-1:0]      req_full;
   logic [2*P-1:0]    out_resp;
   logic [DW*P-1:0]   out_data;
   logic [TW*P-1:0]   out_tag;

   calc_nport #(.PORTS(P), .DATA_W(DW), .QDEPTH(QD), .TAG_W(TW)) dut (
      .c_clk       (c_clk),
      .reset       (reset),
      .req_cmd_in  (req_cmd_in),
      .req_data_in (req_data_in),
      .req_tag_in  (req_tag_in),
      .req_full    (req_full),
      .out_resp    (out_resp),
      .out_data    (out_data),
      .out_tag     (out_tag)
   );

   always #5 c_clk = ~c_clk;

   typedef struct packed {
      logic [3:0]    cmd;
      logic [DW-1:0] a;
      logic [DW-1:0] b;
      logic [TW-1:0] tag;
   } ent_t;

   // reference model state
   ent_t          mq [P][$];
   bit            m_pend [P];
   logic [3:0]    m_cmd  [P];
   logic [DW-1:0] m_op1  [P];
   logic [TW-1:0] m_tag  [P];
   bit            m_dv;
   int            m_dport;
   ent_t          m_dent;
   int            m_ptr;
   logic [1:0]    e_resp [P];
   logic [DW-1:0] e_data [P];
   logic [TW-1:0] e_tag  [P];
   bit            e_full [P];

   int n_checks = 0;
   int n_pass   = 0;

   function automatic void calc(input ent_t e, output logic [1:0] r, output logic [DW-1:0] d);
      logic [DW:0] s;
      int sh;
      sh = int'(e.b % DW);
      r = 2'd3;
      d = '0;
      case (e.cmd)
         4'd1: begin
            s = {1'b0, e.a} + {1'b0, e.b};
            if (s[DW]) r = 2'd2;
            else begin r = 2'd1; d = s[DW-1:0]; end
         end
         4'd2: if (e.b > e.a) r = 2'd2; else begin r = 2'd1; d = e.a - e.b; end
         4'd5: begin r = 2'd1; d = e.a << sh; end
         4'd6: begin r = 2'd1; d = e.a >> sh; end
`ifdef CALC_ROTATE_EN
         4'd9:  begin r = 2'd1; d = (e.a << sh) | (e.a >> (DW - sh)); end
         4'd10: begin r = 2'd1; d = (e.a >> sh) | (e.a << (DW - sh)); end
`endif
         default: ;
      endcase
   endfunction

   task automatic model_reset();
      for (int p = 0; p < P; p++) begin
         mq[p].delete();
         m_pend[p] = 0; m_cmd[p] = '0; m_op1[p] = '0; m_tag[p] = '0;
         e_resp[p] = '0; e_data[p] = '0; e_tag[p] = '0; e_full[p] = 0;
      end
      m_dv = 0; m_dport = 0; m_dent = '0; m_ptr = 0;
   endtask

   // advance the model across one rising edge using the inputs currently driven
   task automatic model_step();
      logic [1:0]    r;
      logic [DW-1:0] d;
      if (reset) begin
         model_reset();
         return;
      end
      for (int p = 0; p < P; p++) begin
         e_resp[p] = '0; e_data[p] = '0; e_tag[p] = '0;
      end
      if (m_dv) begin
         calc(m_dent, r, d);
         e_resp[m_dport] = r;
         e_data[m_dport] = d;
         e_tag[m_dport]  = m_dent.tag;
      end
      m_dv = 0;
      for (int i = 0; i < P; i++) begin
         int q;
         q = (m_ptr + i) % P;
         if (!m_dv && mq[q].size() > 0) begin
            m_dv = 1;
            m_dport = q;
            m_dent = mq[q].pop_front();
         end
      end
      if (m_dv) m_ptr = (m_dport + 1) % P;
      for (int p = 0; p < P; p++) begin
         logic [3:0] c;
         c = req_cmd_in[4*p +: 4];
         if (m_pend[p]) begin
            mq[p].push_back({m_cmd[p], m_op1[p], req_data_in[DW*p +: DW], m_tag[p]});
            m_pend[p] = 0;
         end else if (c != 4'd0 && !e_full[p]) begin
            m_pend[p] = 1;
            m_cmd[p] = c;
            m_op1[p] = req_data_in[DW*p +: DW];
            m_tag[p] = req_tag_in[TW*p +: TW];
         end
         e_full[p] = (mq[p].size() == QD);
      end
   endtask

   task automatic chk(input string name, input int p, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s port %0d: got 0x%0h expected 0x%0h", name, p, obs, exp);
   endtask

   task automatic check_all();
      for (int p = 0; p < P; p++) begin
         chk("resp", p, 64'(out_resp[2*p +: 2]), 64'(e_resp[p]));
         chk("data", p, 64'(out_data[DW*p +: DW]), 64'(e_data[p]));
         chk("tag",  p, 64'(out_tag[TW*p +: TW]), 64'(e_tag[p]));
         chk("full", p, 64'(req_full[p]), 64'(e_full[p]));
      end
   endtask

   task automatic cycle();
      model_step();
      @(negedge c_clk);
      check_all();
   endtask

   task automatic set_port(input int p, input logic [3:0] c, input logic [DW-1:0] d, input logic [TW-1:0] t);
      req_cmd_in[4*p +: 4]   = c;
      req_data_in[DW*p +: DW] = d;
      req_tag_in[TW*p +: TW] = t;
   endtask

   task automatic req(input int p, input logic [3:0] c, input logic [DW-1:0] a, input logic [DW-1:0] b, input logic [TW-1:0] t);
      set_port(p, c, a, t);
      cycle();
      set_port(p, 4'd0, b, '0);
      cycle();
      set_port(p, 4'd0, '0, '0);
   endtask

   // lone request on an idle core: response visible two edges after op2, for one cycle
   task automatic req_expect(input string name, input int p, input logic [3:0] c, input logic [DW-1:0] a,
                             input logic [DW-1:0] b, input logic [TW-1:0] t,
                             input logic [1:0] xr, input logic [DW-1:0] xd);
      req(p, c, a, b, t);
      cycle();
      cycle();
      chk({name, "_resp"}, p, 64'(out_resp[2*p +: 2]), 64'(xr));
      chk({name, "_data"}, p, 64'(out_data[DW*p +: DW]), 64'(xd));
      chk({name, "_tag"},  p, 64'(out_tag[TW*p +: TW]), 64'(t));
      cycle();
      chk({name, "_pulse"}, p, 64'(out_resp[2*p +: 2]), 64'd0);
   endtask

   function automatic logic [DW-1:0] rnd_val();
      logic [DW-1:0] v;
      case ($urandom_range(0, 3))
         0: v = DW'($urandom_range(0, 40));
         1: v = {DW{1'b1}} - DW'($urandom_range(0, 3));
         default: v = DW'($urandom);
      endcase
      return v;
   endfunction

   initial begin
      bit            saw_full2;
      bit            ph [P];
      logic [3:0]    cmds [12];
      logic [2*P-1:0] exp_vec;
      logic [1:0]    rot_r;
      logic [DW-1:0] rot_d;

      cmds = '{4'd1, 4'd2, 4'd5, 4'd6, 4'd9, 4'd10, 4'd3, 4'd4, 4'd7, 4'd15, 4'd1, 4'd2};
      reset = 1'b1;
      req_cmd_in = '0; req_data_in = '0; req_tag_in = '0;
      model_reset();
      @(negedge c_clk);
      @(negedge c_clk);
      check_all();
      reset = 1'b0;

      // two arbitration rounds, both starting at port 0
      for (int rnd = 0; rnd < 2; rnd++) begin
         for (int p = 0; p < P; p++) set_port(p, 4'd1, DW'(p + 1), TW'(p));
         cycle();
         for (int p = 0; p < P; p++) set_port(p, 4'd0, DW'(10), '0);
         cycle();
         for (int p = 0; p < P; p++) set_port(p, 4'd0, '0, '0);
         cycle();
         for (int i = 0; i < P; i++) begin
            cycle();
            exp_vec = (2*P)'(1) << (2*i);
            chk("arb_order", i, 64'(out_resp), 64'(exp_vec));
            chk("arb_data", i, 64'(out_data[DW*i +: DW]), 64'(i + 11));
         end
         repeat (2) cycle();
      end

      req_expect("add", 0, 4'd1, 32'h0000_0005, 32'h0000_0003, 2'd1, 2'd1, 32'h8);
      req_expect("add_ovf", 0, 4'd1, 32'hFFFF_FFFF, 32'h1, 2'd0, 2'd2, 32'h0);
      req_expect("sub_udf", 0, 4'd2, 32'd3, 32'd4, 2'd1, 2'd2, 32'h0);
      req_expect("sub_zero", 0, 4'd2, 32'd4, 32'd4, 2'd2, 2'd1, 32'h0);
      req_expect("shl", 1, 4'd5, 32'h1, 32'd33, 2'd3, 2'd1, 32'h2);
      req_expect("shr", 2, 4'd6, 32'h8000_0000, 32'd31, 2'd0, 2'd1, 32'h1);
      req_expect("shl0", 3, 4'd5, 32'h1234_5678, 32'd64, 2'd1, 2'd1, 32'h1234_5678);
`ifdef CALC_ROTATE_EN
      rot_r = 2'd1; rot_d = 32'h2;
`else
      rot_r = 2'd3; rot_d = 32'h0;
`endif
      req_expect("rotl", 0, 4'd9, 32'h1, 32'h1, 2'd1, rot_r, rot_d);
      req_expect("badcmd", 1, 4'd3, 32'h55, 32'h66, 2'd2, 2'd3, 32'h0);

      // all ports back-to-back: queues fill, later requests are dropped
      saw_full2 = 0;
      for (int r = 0; r < 12; r++) begin
         for (int p = 0; p < P; p++) set_port(p, 4'd1, DW'($urandom_range(0, 1000)), TW'(r));
         cycle();
         if (req_full[2]) saw_full2 = 1;
         for (int p = 0; p < P; p++) set_port(p, 4'd0, DW'($urandom_range(0, 1000)), '0);
         cycle();
         if (req_full[2]) saw_full2 = 1;
      end
      for (int p = 0; p < P; p++) set_port(p, 4'd0, '0, '0);
      chk("saw_full2", 2, 64'(saw_full2), 64'd1);
      repeat (30) cycle();

      // reset while a request is in the dispatch stage
      req(0, 4'd1, 32'd7, 32'd9, 2'd2);
      cycle();
      reset = 1'b1;
      #1;
      model_reset();
      chk("rst_resp", 0, 64'(out_resp), 64'd0);
      chk("rst_full", 0, 64'(req_full), 64'd0);
      check_all();
      cycle();
      reset = 1'b0;
      repeat (3) cycle();
      req_expect("post_rst", 0, 4'd2, 32'd20, 32'd5, 2'd3, 2'd1, 32'd15);

      // randomized traffic
      for (int p = 0; p < P; p++) ph[p] = 0;
      for (int c = 0; c < 800; c++) begin
         for (int p = 0; p < P; p++) begin
            if (ph[p]) begin
               set_port(p, 4'd0, rnd_val(), TW'($urandom));
               ph[p] = 0;
            end else if ($urandom_range(0, 2) != 0) begin
               set_port(p, cmds[$urandom_range(0, 11)], rnd_val(), TW'($urandom));
               ph[p] = 1;
            end else begin
               set_port(p, 4'd0, rnd_val(), TW'($urandom));
            end
         end
         cycle();
      end
      for (int p = 0; p < P; p++) set_port(p, 4'd0, '0, '0);
      repeat (30) cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
